// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - multicycle 16-bit-instruction CPU: FETCH/DECODE/EXEC/MEM/HALT FSM
// with request/ack instruction and data ports.
module cpu_multicycle #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              imem_ack,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic [ADDR_W-1:0] pc,
   output logic              flag_z,
   output logic              flag_c,
   output logic              halted,
   output logic              illegal_op,
   output logic [15:0]       retired
);

   localparam int NREG = 1 << REG_AW;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic              z_q, z_d, cf_q, cf_d, ill_q, ill_d;
   logic [15:0]       ret_q, ret_d;
   logic              imem_req_c, dmem_req_c, dmem_we_c;

   logic [3:0]        op;
   logic [REG_AW-1:0] rd_i, rs_i, rt_i;
   logic [DATA_W-1:0] imm_data;
   logic [ADDR_W-1:0] imm_addr, pc_inc;
   logic [DATA_W:0]   sum, diff;
   logic [DATA_W-1:0] res;
   logic              res_c;

   assign op       = ir_q[15:12];
   assign rd_i     = REG_AW'(ir_q[11:8]);
   assign rs_i     = REG_AW'(ir_q[7:4]);
   assign rt_i     = REG_AW'(ir_q[3:0]);
   assign imm_data = DATA_W'(ir_q[7:0]);
   assign imm_addr = ADDR_W'(ir_q[7:0]);
   assign pc_inc   = pc_q + ADDR_W'(1);

   // diff MSB is the borrow because both operands are zero-extended by one bit
   assign sum  = {1'b0, a_q} + {1'b0, b_q};
   assign diff = {1'b0, a_q} - {1'b0, b_q};

   always_comb begin
      res   = '0;
      res_c = 1'b0;
      case (op)
         4'h1:    begin res = sum[DATA_W-1:0];  res_c = sum[DATA_W];  end
         4'h2:    begin res = diff[DATA_W-1:0]; res_c = diff[DATA_W]; end
         4'h3:    res = a_q & b_q;
         4'h4:    res = a_q | b_q;
         4'h5:    res = a_q ^ b_q;
         default: res = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      a_d        = a_q;
      b_d        = b_q;
      c_d        = c_q;
      regs_d     = regs_q;
      z_d        = z_q;
      cf_d       = cf_q;
      ill_d      = ill_q;
      ret_d      = ret_q;
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d     = regs_q[rs_i];
            b_d     = regs_q[rt_i];
            c_d     = regs_q[rd_i];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
            ret_d   = ret_q + 16'd1;
            case (op)
               4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                  regs_d[rd_i] = res;
                  z_d          = (res == '0);
                  cf_d         = res_c;
               end
               4'h6: regs_d[rd_i] = imm_data;
               4'h7, 4'h8: begin
                  // completion (pc/retired) is deferred to the data ack
                  state_d = S_MEM;
                  pc_d    = pc_q;
                  ret_d   = ret_q;
               end
               4'h9: pc_d = imm_addr;
               4'hA: if (c_q == '0) pc_d = imm_addr;
               4'hF: state_d = S_HALT;
               4'h0: ;
               default: ill_d = 1'b1;
            endcase
         end
         S_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = (op == 4'h8);
            if (dmem_ack) begin
               if (op == 4'h7) regs_d[rd_i] = dmem_rdata;
               pc_d    = pc_inc;
               ret_d   = ret_q + 16'd1;
               state_d = S_FETCH;
            end
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         regs_q  <= '{default: '0};
         z_q     <= 1'b0;
         cf_q    <= 1'b0;
         ill_q   <= 1'b0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         regs_q  <= regs_d;
         z_q     <= z_d;
         cf_q    <= cf_d;
         ill_q   <= ill_d;
         ret_q   <= ret_d;
      end
   end

   // rst gates the requests combinationally so an in-flight access drops at once
   assign imem_req   = imem_req_c & ~rst;
   assign dmem_req   = dmem_req_c & ~rst;
   assign dmem_we    = dmem_we_c & ~rst;
   assign imem_addr  = pc_q;
   assign dmem_addr  = ADDR_W'(a_q);
   assign dmem_wdata = c_q;
   assign pc         = pc_q;
   assign flag_z     = z_q;
   assign flag_c     = cf_q;
   assign halted     = (state_q == S_HALT);
   assign illegal_op = ill_q;
   assign retired    = ret_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb/tb_cpu_multicycle.sv - directed self-checking bench for cpu_multicycle with
// zero-wait instruction memory and a programmable-latency data memory.
module tb_cpu_multicycle;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int REG_AW = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              imem_req, imem_ack;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_rdata;
   logic              dmem_req, dmem_we;
   logic              dmem_ack = 1'b0;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
   logic [ADDR_W-1:0] pc;
   logic              flag_z, flag_c, halted, illegal_op;
   logic [15:0]       retired;

   logic [15:0] prog [256];
   logic [7:0]  dmem [256];

   int checks = 0;
   int errors = 0;

   int   dly = 0;
   int   cnt = 0;
   bit   in_acc = 1'b0;
   int   n_acc = 0;
   int   acc_cycles [8];
   bit   acc_stable [8];
   bit   acc_we [8];
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic              s_we;
   int   cyc;

   always #5 clk = ~clk;

   cpu_multicycle #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .pc(pc), .flag_z(flag_z), .flag_c(flag_c), .halted(halted), .illegal_op(illegal_op),
      .retired(retired)
   );

   assign imem_ack   = imem_req;
   assign imem_rdata = prog[imem_addr];
   assign dmem_rdata = dmem[dmem_addr];

   // data memory: acks after dly wait cycles, records length and stability of each access
   always @(negedge clk) begin
      if (dmem_req) begin
         if (!in_acc) begin
            in_acc  = 1'b1;
            cnt     = 0;
            s_addr  = dmem_addr;
            s_wdata = dmem_wdata;
            s_we    = dmem_we;
            if (n_acc < 8) acc_stable[n_acc] = 1'b1;
         end else if (dmem_addr !== s_addr || dmem_wdata !== s_wdata || dmem_we !== s_we) begin
            if (n_acc < 8) acc_stable[n_acc] = 1'b0;
         end
         if (cnt == dly) begin
            dmem_ack = 1'b1;
            if (dmem_we) dmem[dmem_addr] = dmem_wdata;
            if (n_acc < 8) begin
               acc_cycles[n_acc] = cnt + 1;
               acc_we[n_acc]     = dmem_we;
            end
            n_acc  = n_acc + 1;
            in_acc = 1'b0;
         end else begin
            dmem_ack = 1'b0;
         end
         cnt = cnt + 1;
      end else begin
         dmem_ack = 1'b0;
         in_acc   = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         prog[i] = 16'hF000;
         dmem[i] = 8'h00;
      end
      n_acc = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_to_halt(output int cycles);
      cycles = 0;
      while (!halted && cycles < 200) begin
         @(posedge clk);
         cycles++;
         #1;
      end
      check("halted", halted, 1);
   endtask

   task automatic wait_ret(input int n);
      int k;
      k = 0;
      while (retired != 16'(n) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("ret_reach", retired, n);
   endtask

   initial begin
      clear_mem();
      #1;
      check("rst_pc", pc, 0);
      check("rst_imem_req", imem_req, 0);
      check("rst_dmem_req", dmem_req, 0);
      check("rst_retired", retired, 0);
      check("rst_halted", halted, 0);
      check("rst_flags", {flag_z, flag_c, illegal_op}, 0);

      // basic program, zero-wait memory
      prog[0] = 16'h6105; prog[1] = 16'h6203; prog[2] = 16'h1312; prog[3] = 16'hF000;
      do_reset();
      run_to_halt(cyc);
      check("t1_cycles", cyc, 12);
      check("t1_r3", dut.regs_q[3], 8'h08);
      check("t1_z", flag_z, 0);
      check("t1_retired", retired, 4);

      // flags, logic ops, aliasing
      clear_mem();
      prog[0] = 16'h61FF; prog[1] = 16'h6201; prog[2] = 16'h1312; prog[3] = 16'h3512;
      prog[4] = 16'h5611; prog[5] = 16'h6410; prog[6] = 16'h2421; prog[7] = 16'h4734;
      prog[8] = 16'h1111; prog[9] = 16'hF000;
      do_reset();
      wait_ret(3);
      check("add_r3", dut.regs_q[3], 8'h00);
      check("add_zc", {flag_z, flag_c}, 2'b11);
      wait_ret(4);
      check("and_r5", dut.regs_q[5], 8'h01);
      check("and_zc", {flag_z, flag_c}, 2'b00);
      wait_ret(5);
      check("xor_r6", dut.regs_q[6], 8'h00);
      check("xor_zc", {flag_z, flag_c}, 2'b10);
      wait_ret(6);
      check("li_r4", dut.regs_q[4], 8'h10);
      check("li_zc", {flag_z, flag_c}, 2'b10);
      wait_ret(7);
      check("sub_r4", dut.regs_q[4], 8'h02);
      check("sub_zc", {flag_z, flag_c}, 2'b01);
      wait_ret(8);
      check("or_r7", dut.regs_q[7], 8'h02);
      check("or_zc", {flag_z, flag_c}, 2'b00);
      wait_ret(9);
      check("alias_r1", dut.regs_q[1], 8'hFE);
      check("alias_zc", {flag_z, flag_c}, 2'b01);

      // store then load with 3 wait cycles
      clear_mem();
      dly = 3;
      prog[0] = 16'h6120; prog[1] = 16'h62A5; prog[2] = 16'h8210; prog[3] = 16'h7310;
      prog[4] = 16'hF000;
      do_reset();
      run_to_halt(cyc);
      check("mem_cycles", cyc, 23);
      check("mem_nacc", n_acc, 2);
      check("st_len", acc_cycles[0], 4);
      check("st_we", acc_we[0], 1);
      check("st_stable", acc_stable[0], 1);
      check("st_data", dmem[8'h20], 8'hA5);
      check("ld_len", acc_cycles[1], 4);
      check("ld_we", acc_we[1], 0);
      check("ld_stable", acc_stable[1], 1);
      check("ld_r3", dut.regs_q[3], 8'hA5);
      check("mem_retired", retired, 5);
      dly = 0;

      // branches and pc wrap
      clear_mem();
      prog[0] = 16'h6100; prog[1] = 16'hA105; prog[5] = 16'h6201; prog[6] = 16'hA210;
      prog[7] = 16'h90FF; prog[255] = 16'h0000;
      do_reset();
      wait_ret(1); check("br_pc1", pc, 8'h01);
      wait_ret(2); check("beqz_taken", pc, 8'h05);
      wait_ret(3); check("br_pc6", pc, 8'h06);
      wait_ret(4); check("beqz_not", pc, 8'h07);
      wait_ret(5); check("jmp_ff", pc, 8'hFF);
      wait_ret(6); check("pc_wrap", pc, 8'h00);

      // illegal opcode
      clear_mem();
      prog[0] = 16'h61FF; prog[1] = 16'h6201; prog[2] = 16'h1312; prog[3] = 16'hC312;
      prog[4] = 16'hF000;
      do_reset();
      wait_ret(3);
      check("ill_before", illegal_op, 0);
      wait_ret(4);
      check("ill_pc", pc, 8'h04);
      check("ill_set", illegal_op, 1);
      check("ill_r3", dut.regs_q[3], 8'h00);
      check("ill_zc", {flag_z, flag_c}, 2'b11);
      run_to_halt(cyc);
      check("ill_sticky", illegal_op, 1);
      check("ill_retired", retired, 5);

      // reset in the middle of a load
      clear_mem();
      dly = 5;
      dmem[8'h30] = 8'h77;
      prog[0] = 16'h6130; prog[1] = 16'hD000; prog[2] = 16'h6209; prog[3] = 16'h7310;
      prog[4] = 16'hF000;
      do_reset();
      begin
         int k;
         k = 0;
         while (!dmem_req && k < 100) begin
            @(negedge clk);
            k++;
         end
      end
      check("mr_req_seen", dmem_req, 1);
      @(negedge clk);
      @(negedge clk);
      check("mr_pre_ret", retired, 3);
      check("mr_pre_ill", illegal_op, 1);
      #2 rst = 1'b1;
      #1;
      check("mr_req_drop", dmem_req, 0);
      check("mr_pc", pc, 0);
      check("mr_retired", retired, 0);
      check("mr_ill", illegal_op, 0);
      check("mr_r1", dut.regs_q[1], 8'h00);
      check("mr_r3", dut.regs_q[3], 8'h00);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mr_fetch_req", imem_req, 1);
      check("mr_fetch_addr", imem_addr, 0);
      dly = 0;
      wait_ret(1);
      check("mr_restart_r1", dut.regs_q[1], 8'h30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_multicycle.md
CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 Parameter DATA_W, default 8: register, ALU and data-bus width; legal range 8..32.
REQ-002 Parameter ADDR_W, default 8: instruction and data address width; legal range 4..16.
REQ-003 Parameter REG_AW, default 3: register index width; 2^REG_AW registers; legal range 1..4.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  ADDR_W  fetch address, equal to pc.
REQ-008 imem_rdata  input  16  instruction word, valid when imem_ack=1.
REQ-009 imem_ack  input  1  fetch complete.
REQ-010 dmem_req / dmem_we  output  1 / 1  data access request / write qualifier.
REQ-011 dmem_addr  output  ADDR_W  data address.
REQ-012 dmem_wdata  output  DATA_W  store data.
REQ-013 dmem_rdata  input  DATA_W  load data, valid when dmem_ack=1.
REQ-014 dmem_ack  input  1  data access complete.
REQ-015 pc  output  ADDR_W  current program counter.
REQ-016 flag_z / flag_c  output  1 / 1  zero / carry flags.
REQ-017 halted / illegal_op  output  1 / 1  HALT reached / sticky illegal-opcode indicator.
REQ-018 retired  output  16  count of completed instructions.

Function
REQ-019 Instruction fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm=[7:0]; register indices use the low REG_AW bits of each field; imm is zero-extended to DATA_W or ADDR_W.
REQ-020 Opcodes: 0 NOP; 1 ADD rd=rs+rt; 2 SUB rd=rs-rt; 3 AND; 4 OR; 5 XOR; 6 LI rd=imm; 7 LD rd=mem[rs]; 8 ST mem[rs]=rd; 9 JMP pc=imm; A BEQZ (pc=imm if rd==0); F HALT; B-E illegal.
REQ-021 FSM states: FETCH, DECODE, EXEC, MEM, HALT; reset state is FETCH.
REQ-022 FETCH: imem_req=1 with imem_addr=pc until imem_ack; the instruction is latched on the ack cycle, then the FSM moves to DECODE.
REQ-023 DECODE (1 cycle): operands are read from the register file; the FSM moves to EXEC.
REQ-024 EXEC (1 cycle): ALU ops and LI write rd; JMP/BEQZ/NOP/illegal update pc; all of these return to FETCH. LD/ST go to MEM. HALT goes to HALT.
REQ-025 MEM: dmem_req=1; dmem_addr = low ADDR_W bits of rs; dmem_we=1 for ST; dmem_wdata=rd; outputs are held stable until dmem_ack. LD writes rd from dmem_rdata on the ack cycle; the FSM then moves to FETCH.
REQ-026 Zero-wait acks (ack in the first request cycle) are legal; minimum latency is 3 cycles for non-memory instructions and 4 cycles for LD/ST; wait cycles extend FETCH or MEM only.
REQ-027 An ack received while the matching req=0 is ignored.
REQ-028 pc advances by 1 modulo 2^ADDR_W at completion of every instruction except taken JMP/BEQZ; pc wraps from all-ones to 0.
REQ-029 ADD/SUB: result is truncated to DATA_W; flag_c = carry out (ADD) or borrow (SUB).
REQ-030 AND/OR/XOR: flag_c is cleared.
REQ-031 flag_z is set to (result==0) by ops 1-5 only; other instructions leave both flags unchanged.
REQ-032 rd=rs=rt aliasing is legal; operands are the pre-write values.
REQ-033 Illegal opcode: executes as NOP (pc+1, retired+1) and sets illegal_op, which stays 1 until reset.
REQ-034 retired increments by 1 when each instruction completes (including NOP, illegal and HALT); it wraps 0xFFFF->0.
REQ-035 HALT state: halted=1, no requests issued, pc frozen; exit only by reset.

Reset
REQ-036 While rst=1, asynchronously: state=FETCH; pc=0; all registers=0; flag_z=flag_c=0; halted=illegal_op=0; retired=0; imem_req=dmem_req=dmem_we=0.
REQ-037 rst asserted mid-FETCH or mid-MEM drops the req immediately and abandons the access; no register write and no retired increment occur for it.
REQ-038 After rst deasserts, the first rising edge starts FETCH at address 0.

Verification
REQ-039 Zero-wait memory, program LI r1,5; LI r2,3; ADD r3,r1,r2; HALT -> r3=8, flag_z=0, retired=4, halted at cycle 12.
REQ-040 DATA_W=8, LI r1,0xFF; LI r2,1; ADD r3,r1,r2 -> r3=0x00, flag_z=1, flag_c=1; then SUB r4,r2,r1 -> r4=0x02, flag_c=1.
REQ-041 ST then LD with dmem_ack delayed 3 cycles -> dmem_req/addr/wdata stable for 4 cycles; loaded register equals the stored value.
REQ-042 BEQZ taken and not-taken, plus JMP to 0xFF with ADDR_W=8 followed by NOP -> pc=0xFF, then pc=0x00.
REQ-043 Opcode 0xC -> illegal_op=1 (sticky), pc+1, retired+1; no register or flag change.
REQ-044 rst pulsed mid-MEM of an LD -> dmem_req drops in the same cycle; after release pc=0, registers=0, retired=0, illegal_op=0.
